// File: rtl/sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader
//
// Drain stage for a synchronous FIFO with registered (non-FWFT) read data.
// Read requests are issued early enough to keep one word per cycle flowing.
// The one-cycle read latency is absorbed by a 2-entry skid buffer. Words are
// presented as a valid/ready stream, and last_o marks every PACKET_LEN-th word.
//
// Parameters
//   DATA_WIDTH      word width, equal to the upstream FIFO width
//   PACKET_LEN      words per packet (1..65535)
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   fifo_empty_i    upstream FIFO empty flag
//   fifo_rd_data_i  upstream read data, valid the cycle after fifo_read_o
//   fifo_read_o     read request to the upstream FIFO (combinational)
//   flush_i         discard buffered and in-flight words
//   ready_i         sink ready
//   valid_o         stream word valid (registered)
//   data_o          stream word (registered)
//   last_o          final word of a packet (registered, qualified by valid_o)
//
// Optional feature, macro SYNC_FIFO_STREAM_READER_STATS_EN:
//   beat_count_o    saturating count of accepted words
//   stall_count_o   saturating count of cycles with valid_o & !ready_i
//   Only rst_i clears these counters; flush_i does not.
// -----------------------------------------------------------------------------
module sync_fifo_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int PACKET_LEN = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_read_o,
   input  logic                  flush_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
  ,output logic [15:0]           beat_count_o,
   output logic [15:0]           stall_count_o
`endif
);

   localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

   logic [1:0]            occ_r;
   logic                  pend_r;
   logic [BEAT_W-1:0]     beat_r;
   logic [DATA_WIDTH-1:0] data0_r;
   logic [DATA_WIDTH-1:0] data1_r;
   logic                  valid_r;
   logic                  last_r;

   logic                  pop_s;
   logic [1:0]            level_s;
   logic                  read_s;
   logic [1:0]            tail_s;
   logic [1:0]            occ_n_s;
   logic [BEAT_W-1:0]     beat_n_s;
   logic [DATA_WIDTH-1:0] data0_n_s;
   logic [DATA_WIDTH-1:0] data1_n_s;

   // Read request: a new read is allowed only if the buffer will still have
   // room once every outstanding word has landed. occ + pend never exceeds 2,
   // so a 2-bit level is wide enough.
   always_comb begin
      pop_s   = valid_r & ready_i;
      level_s = occ_r + {1'b0, pend_r} - {1'b0, pop_s};
      read_s  = ~rst_i & ~flush_i & ~fifo_empty_i & (level_s < 2'd2);
   end

   assign fifo_read_o = read_s;

   // Next skid contents: shift on pop first, then the arriving word lands in
   // the first free slot behind whatever is left.
   always_comb begin
      data0_n_s = data0_r;
      data1_n_s = data1_r;
      tail_s    = occ_r - {1'b0, pop_s};
      if (pop_s) begin
         data0_n_s = data1_r;
      end else begin
         data0_n_s = data0_r;
      end
      if (pend_r) begin
         if (tail_s == 2'd0) begin
            data0_n_s = fifo_rd_data_i;
         end else begin
            data1_n_s = fifo_rd_data_i;
         end
      end else begin
         data1_n_s = data1_r;
      end
      if (flush_i) begin
         occ_n_s = 2'd0;
      end else begin
         occ_n_s = tail_s + {1'b0, pend_r};
      end
   end

   // Packet position: a pop advances the position and flush restarts the packet.
   // A word popped in the flush cycle has still been delivered.
   always_comb begin
      beat_n_s = beat_r;
      if (flush_i) begin
         beat_n_s = {BEAT_W{1'b0}};
      end else if (pop_s) begin
         if (beat_r == LAST_BEAT) begin
            beat_n_s = {BEAT_W{1'b0}};
         end else begin
            beat_n_s = beat_r + BEAT_W'(1);
         end
      end else begin
         beat_n_s = beat_r;
      end
   end

   // State and output registers. valid/last are computed from the next state,
   // so the outputs never depend combinationally on ready_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_r   <= 2'd0;
         pend_r  <= 1'b0;
         beat_r  <= {BEAT_W{1'b0}};
         data0_r <= {DATA_WIDTH{1'b0}};
         data1_r <= {DATA_WIDTH{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         occ_r   <= occ_n_s;
         pend_r  <= read_s;
         beat_r  <= beat_n_s;
         data0_r <= data0_n_s;
         data1_r <= data1_n_s;
         valid_r <= (occ_n_s != 2'd0);
         last_r  <= (occ_n_s != 2'd0) & (beat_n_s == LAST_BEAT);
      end
   end

   assign valid_o = valid_r;
   assign data_o  = data0_r;
   assign last_o  = last_r;

`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
   logic [15:0] beat_cnt_r;
   logic [15:0] stall_cnt_r;

   // Saturating transfer and stall counters, unaffected by flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_cnt_r  <= 16'h0000;
         stall_cnt_r <= 16'h0000;
      end else begin
         if (pop_s && (beat_cnt_r != 16'hFFFF)) begin
            beat_cnt_r <= beat_cnt_r + 16'h0001;
         end else begin
            beat_cnt_r <= beat_cnt_r;
         end
         if (valid_r && !ready_i && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign beat_count_o  = beat_cnt_r;
   assign stall_count_o = stall_cnt_r;
`endif

endmodule
